// File: rtl/sync_signal_pkg.sv
// -----------------------------------------------------------------------------
// sync_signal_pkg
// Shared definitions for the sync_signal_filt synchroniser/glitch-filter slice.
//   - clog2          : constant-evaluable ceiling log2
//   - cnt_width      : width of the per-channel persistence counter
//   - DEFAULT_RST_BIT: default per-channel reset level
//   - MIN_*          : smallest legal SYNC_STAGES / FILT_CYCLES
//   - params_legal   : used by the top level to reject illegal parameter sets
// No ports (package).
// -----------------------------------------------------------------------------
package sync_signal_pkg;

    localparam int MIN_SYNC_STAGES = 2;
    localparam int MIN_FILT_CYCLES = 1;
    localparam int MIN_BUS_WIDTH   = 1;

    localparam logic DEFAULT_RST_BIT = 1'b0;

    // Ceiling log2, usable in constant expressions; clog2(1) is 0.
    function automatic int clog2(input int value);
        int result;
        int remaining;
        result    = 0;
        remaining = value - 1;
        while (remaining > 0) begin
            result    = result + 1;
            remaining = remaining >> 1;
        end
        return result;
    endfunction

    // The counter has to hold 0..FILT_CYCLES-1; FILT_CYCLES+1 keeps the
    // width at least one bit even for FILT_CYCLES == 1.
    function automatic int cnt_width(input int filt_cycles);
        return clog2(filt_cycles + 1);
    endfunction

    function automatic bit params_legal(input int bus_width,
                                        input int sync_stages,
                                        input int filt_cycles);
        return (bus_width >= MIN_BUS_WIDTH) &&
               (sync_stages >= MIN_SYNC_STAGES) &&
               (filt_cycles >= MIN_FILT_CYCLES);
    endfunction

endpackage

// File: rtl/sync_signal_filt_bit.sv
// -----------------------------------------------------------------------------
// sync_signal_filt_bit
// One channel of sync_signal_filt: flop synchroniser chain, persistence
// counter, filtered output bit and (optionally) registered edge pulses.
// Optional feature macro: SYNC_SIGNAL_FILT_EDGE_EN (edge pulse flops).
// Ports:
//   clk      in   channel clock, rising edge
//   rst      in   asynchronous active-high reset
//   i_sig    in   raw asynchronous input bit
//   o_level  out  synchronised, filtered level (registered)
//   o_busy   out  high while the synchronised value differs from o_level
//   o_rise   out  one-cycle pulse on a 0->1 update of o_level (0 if disabled)
//   o_fall   out  one-cycle pulse on a 1->0 update of o_level (0 if disabled)
// -----------------------------------------------------------------------------
module sync_signal_filt_bit
    import sync_signal_pkg::*;
#(
    parameter int   SYNC_STAGES = 2,
    parameter int   FILT_CYCLES = 4,
    parameter logic RST_BIT     = DEFAULT_RST_BIT
) (
    input  logic clk,
    input  logic rst,
    input  logic i_sig,
    output logic o_level,
    output logic o_busy,
    output logic o_rise,
    output logic o_fall
);

    localparam int CNT_W = cnt_width(FILT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILT_CYCLES - 1);

    logic [SYNC_STAGES-1:0] chain_q;
    logic [SYNC_STAGES-1:0] chain_d;
    logic [CNT_W-1:0]       cnt_q;
    logic [CNT_W-1:0]       cnt_d;
    logic                   level_q;
    logic                   level_d;
    logic                   s;
    logic                   update;

    // s is the last synchroniser stage; only it is safe to compare.
    assign s = chain_q[SYNC_STAGES-1];

    // The counter only advances while s disagrees with the output; any
    // agreement (including a glitch that goes away) restarts it from zero.
    always_comb begin
        chain_d = {chain_q[SYNC_STAGES-2:0], i_sig};
        update  = (s != level_q) && (cnt_q == CNT_LAST);
        level_d = update ? s : level_q;
        if ((s == level_q) || update) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chain_q <= {SYNC_STAGES{RST_BIT}};
            cnt_q   <= '0;
            level_q <= RST_BIT;
        end else begin
            chain_q <= chain_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
        end
    end

    assign o_level = level_q;
    assign o_busy  = s != level_q;

`ifdef SYNC_SIGNAL_FILT_EDGE_EN
    logic rise_q;
    logic rise_d;
    logic fall_q;
    logic fall_d;

    // Pulses fire on the same edge that updates the output, so they line
    // up with the new level rather than trailing it.
    always_comb begin
        rise_d = update && s;
        fall_d = update && !s;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign o_rise = rise_q;
    assign o_fall = fall_q;
`else
    assign o_rise = 1'b0;
    assign o_fall = 1'b0;
`endif

endmodule

// File: rtl/sync_signal_filt.sv
// -----------------------------------------------------------------------------
// sync_signal_filt
// BUS_WIDTH independent channels, each an N-stage synchroniser followed by a
// glitch filter that only lets a new level through after it has persisted
// for FILT_CYCLES cycles.
// Optional feature macro: SYNC_SIGNAL_FILT_EDGE_EN (registered o_rise/o_fall;
// when undefined both ports stay present and are tied to 0).
// Ports:
//   I_CLK          in   sole clock, rising edge
//   I_RST          in   asynchronous active-high reset
//   i_signal       in   [BUS_WIDTH] raw asynchronous inputs
//   o_signal_sync  out  [BUS_WIDTH] synchronised, filtered level (registered)
//   o_busy         out  [BUS_WIDTH] channel's synchronised value != output
//   o_rise         out  [BUS_WIDTH] one-cycle pulse on 0->1 output update
//   o_fall         out  [BUS_WIDTH] one-cycle pulse on 1->0 output update
// -----------------------------------------------------------------------------
module sync_signal_filt
    import sync_signal_pkg::*;
#(
    parameter int                   BUS_WIDTH   = 8,
    parameter int                   SYNC_STAGES = 2,
    parameter int                   FILT_CYCLES = 4,
    parameter logic [BUS_WIDTH-1:0] RST_VAL     = {BUS_WIDTH{DEFAULT_RST_BIT}}
) (
    input  logic                 I_CLK,
    input  logic                 I_RST,
    input  logic [BUS_WIDTH-1:0] i_signal,
    output logic [BUS_WIDTH-1:0] o_signal_sync,
    output logic [BUS_WIDTH-1:0] o_busy,
    output logic [BUS_WIDTH-1:0] o_rise,
    output logic [BUS_WIDTH-1:0] o_fall
);

    if (!params_legal(BUS_WIDTH, SYNC_STAGES, FILT_CYCLES)) begin : g_bad_params
        $error("sync_signal_filt: need BUS_WIDTH>=1, SYNC_STAGES>=2, FILT_CYCLES>=1");
    end

    // Channels share nothing but clock and reset.
    for (genvar g = 0; g < BUS_WIDTH; g++) begin : g_chan
        sync_signal_filt_bit #(
            .SYNC_STAGES (SYNC_STAGES),
            .FILT_CYCLES (FILT_CYCLES),
            .RST_BIT     (RST_VAL[g])
        ) u_bit (
            .clk     (I_CLK),
            .rst     (I_RST),
            .i_sig   (i_signal[g]),
            .o_level (o_signal_sync[g]),
            .o_busy  (o_busy[g]),
            .o_rise  (o_rise[g]),
            .o_fall  (o_fall[g])
        );
    end

endmodule

// File: tb/tb_sync_signal_filt.sv
// -----------------------------------------------------------------------------
// tb_sync_signal_filt
// Drives two instances of sync_signal_filt (N=2/F=4 and N=3/F=1) from one
// clock and reset. Expected per-cycle outputs come from a closed-form
// description of each pulse/step scenario and pass through a scoreboard queue.
// Honours SYNC_SIGNAL_FILT_EDGE_EN to decide whether edge pulses are expected.
// -----------------------------------------------------------------------------
module tb_sync_signal_filt;

    localparam int BW   = 8;
    localparam int N_A  = 2;
    localparam int F_A  = 4;
    localparam int N_B  = 3;
    localparam int F_B  = 1;
    localparam int STEP = 1000;

`ifdef SYNC_SIGNAL_FILT_EDGE_EN
    localparam bit EDGE_EN = 1'b1;
`else
    localparam bit EDGE_EN = 1'b0;
`endif

    typedef struct packed {
        logic [BW-1:0] level;
        logic [BW-1:0] busy;
        logic [BW-1:0] rise;
        logic [BW-1:0] fall;
    } exp_t;

    logic          I_CLK = 1'b0;
    logic          I_RST = 1'b1;
    logic [BW-1:0] sig_a = 8'hA5;
    logic [BW-1:0] sig_b = 8'h00;
    logic [BW-1:0] sync_a, busy_a, rise_a, fall_a;
    logic [BW-1:0] sync_b, busy_b, rise_b, fall_b;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    always #5 I_CLK = ~I_CLK;

    sync_signal_filt #(
        .BUS_WIDTH   (BW),
        .SYNC_STAGES (N_A),
        .FILT_CYCLES (F_A),
        .RST_VAL     (8'h00)
    ) dut_a (
        .I_CLK         (I_CLK),
        .I_RST         (I_RST),
        .i_signal      (sig_a),
        .o_signal_sync (sync_a),
        .o_busy        (busy_a),
        .o_rise        (rise_a),
        .o_fall        (fall_a)
    );

    sync_signal_filt #(
        .BUS_WIDTH   (BW),
        .SYNC_STAGES (N_B),
        .FILT_CYCLES (F_B),
        .RST_VAL     (8'h00)
    ) dut_b (
        .I_CLK         (I_CLK),
        .I_RST         (I_RST),
        .i_signal      (sig_b),
        .o_signal_sync (sync_b),
        .o_busy        (busy_b),
        .o_rise        (rise_b),
        .o_fall        (fall_b)
    );

    // Expected outputs after edge t for a settled channel set (all at 'base')
    // whose 'mask' bits are inverted for w cycles starting with the input
    // captured at edge c. The synchronised value flips after edge c+n-1; the
    // output follows after edge c+n+f-1 only if w >= f.
    function automatic exp_t model_cycle(input int n, input int f, input int t,
                                         input int c, input int w,
                                         input logic [BW-1:0] base,
                                         input logic [BW-1:0] mask);
        exp_t e;
        int   u;
        bit   passed;
        bit   s_new;
        bit   lvl_new;
        e      = '0;
        u      = c + n + f - 1;
        passed = (w >= f);
        for (int b = 0; b < BW; b++) begin
            s_new   = mask[b] && (t >= c + n - 1) && (t <= c + n - 2 + w);
            lvl_new = mask[b] && passed && (t >= u) && (t <= u + w - 1);
            e.level[b] = base[b] ^ lvl_new;
            e.busy[b]  = s_new ^ lvl_new;
            if (EDGE_EN && mask[b] && passed) begin
                if (t == u) begin
                    e.rise[b] = ~base[b];
                    e.fall[b] = base[b];
                end
                if (t == u + w) begin
                    e.rise[b] = base[b];
                    e.fall[b] = ~base[b];
                end
            end
        end
        return e;
    endfunction

    function automatic string fmt(input exp_t v);
        return $sformatf("level=%h busy=%h rise=%h fall=%h", v.level, v.busy, v.rise, v.fall);
    endfunction

    // Drive one cycle of a scenario, push its expectation, clock, and pop
    // the expectation alongside the observed outputs.
    task automatic step(input int sel, input int n, input int f, input int t,
                        input int c, input int w,
                        input logic [BW-1:0] base, input logic [BW-1:0] mask,
                        output exp_t got, output exp_t exp);
        logic [BW-1:0] stim;
        stim = ((t >= c) && (t < c + w)) ? (base ^ mask) : base;
        if (sel == 0) sig_a = stim;
        else          sig_b = stim;
        sb_q.push_back(model_cycle(n, f, t, c, w, base, mask));
        @(posedge I_CLK);
        #1;
        if (sel == 0) got = '{sync_a, busy_a, rise_a, fall_a};
        else          got = '{sync_b, busy_b, rise_b, fall_b};
        exp = sb_q.pop_front();
    endtask

    task automatic test_reset();
        exp_t got, exp;
        repeat (3) @(posedge I_CLK);
        #2;
        got = '{sync_a, busy_a, rise_a, fall_a};
        checks++;
        if (got !== exp_t'('0)) begin
            errors++;
            $display("[TB] FAIL reset_state_a got %s required all zero", fmt(got));
        end
        got = '{sync_b, busy_b, rise_b, fall_b};
        checks++;
        if (got !== exp_t'('0)) begin
            errors++;
            $display("[TB] FAIL reset_state_b got %s required all zero", fmt(got));
        end
        @(posedge I_CLK);
        #1;
        I_RST = 1'b0;
        // Input has been A5 throughout reset: seen as a step from 00.
        for (int t = 0; t < 10; t++) begin
            step(0, N_A, F_A, t, 0, STEP, 8'h00, 8'hA5, got, exp);
            checks++;
            if (got !== exp) begin
                errors++;
                $display("[TB] FAIL reset_release t=%0d got %s required %s", t, fmt(got), fmt(exp));
            end
        end
        for (int t = 0; t < 10; t++) begin
            step(0, N_A, F_A, t, 0, STEP, 8'hA5, 8'hA5, got, exp);
            checks++;
            if (got !== exp) begin
                errors++;
                $display("[TB] FAIL step_down t=%0d got %s required %s", t, fmt(got), fmt(exp));
            end
        end
    endtask

    task automatic test_glitch_reject();
        exp_t got, exp;
        for (int t = 0; t < 12; t++) begin
            step(0, N_A, F_A, t, 1, F_A - 1, 8'h00, 8'h01, got, exp);
            checks++;
            if (got !== exp) begin
                errors++;
                $display("[TB] FAIL glitch t=%0d got %s required %s", t, fmt(got), fmt(exp));
            end
        end
    endtask

    task automatic test_threshold_pass();
        exp_t got, exp;
        for (int t = 0; t < 16; t++) begin
            step(0, N_A, F_A, t, 1, F_A, 8'h00, 8'h01, got, exp);
            checks++;
            if (got !== exp) begin
                errors++;
                $display("[TB] FAIL threshold t=%0d got %s required %s", t, fmt(got), fmt(exp));
            end
        end
    endtask

    task automatic test_simultaneous();
        exp_t got, exp;
        for (int t = 0; t < 10; t++) begin
            step(0, N_A, F_A, t, 0, STEP, 8'h00, 8'hFF, got, exp);
            checks++;
            if (got !== exp) begin
                errors++;
                $display("[TB] FAIL simul_up t=%0d got %s required %s", t, fmt(got), fmt(exp));
            end
        end
        for (int t = 0; t < 10; t++) begin
            step(0, N_A, F_A, t, 0, STEP, 8'hFF, 8'hFF, got, exp);
            checks++;
            if (got !== exp) begin
                errors++;
                $display("[TB] FAIL simul_down t=%0d got %s required %s", t, fmt(got), fmt(exp));
            end
        end
    endtask

    task automatic test_reset_mid_filter();
        exp_t got, exp;
        // After edge 3 the bit0 counter sits at 2, well short of an update.
        for (int t = 0; t < 4; t++) begin
            step(0, N_A, F_A, t, 0, STEP, 8'h00, 8'h01, got, exp);
            checks++;
            if (got !== exp) begin
                errors++;
                $display("[TB] FAIL mid_filter_pre t=%0d got %s required %s", t, fmt(got), fmt(exp));
            end
        end
        #1;
        I_RST = 1'b1;
        #1;
        got = '{sync_a, busy_a, rise_a, fall_a};
        checks++;
        if (got !== exp_t'('0)) begin
            errors++;
            $display("[TB] FAIL mid_filter_async got %s required all zero", fmt(got));
        end
        #1;
        I_RST = 1'b0;
        for (int t = 0; t < 10; t++) begin
            step(0, N_A, F_A, t, 0, STEP, 8'h00, 8'h01, got, exp);
            checks++;
            if (got !== exp) begin
                errors++;
                $display("[TB] FAIL mid_filter_restart t=%0d got %s required %s", t, fmt(got), fmt(exp));
            end
        end
        for (int t = 0; t < 10; t++) begin
            step(0, N_A, F_A, t, 0, STEP, 8'h01, 8'h01, got, exp);
            checks++;
            if (got !== exp) begin
                errors++;
                $display("[TB] FAIL mid_filter_clear t=%0d got %s required %s", t, fmt(got), fmt(exp));
            end
        end
    endtask

    task automatic test_params();
        exp_t got, exp;
        // F=1: even a single-cycle pulse passes, as an extra register stage.
        for (int t = 0; t < 8; t++) begin
            step(1, N_B, F_B, t, 1, 1, 8'h00, 8'h3C, got, exp);
            checks++;
            if (got !== exp) begin
                errors++;
                $display("[TB] FAIL params_pulse t=%0d got %s required %s", t, fmt(got), fmt(exp));
            end
        end
        for (int t = 0; t < 7; t++) begin
            step(1, N_B, F_B, t, 0, STEP, 8'h00, 8'h81, got, exp);
            checks++;
            if (got !== exp) begin
                errors++;
                $display("[TB] FAIL params_step t=%0d got %s required %s", t, fmt(got), fmt(exp));
            end
        end
    endtask

    initial begin
        $display("[TB] start, edge pulses %s", EDGE_EN ? "enabled" : "disabled");
        test_reset();
        test_glitch_reject();
        test_threshold_pass();
        test_simultaneous();
        test_reset_mid_filter();
        test_params();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
